// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT polynomial multiply controller.
// Holds parameter defaults, the controller state enum and an index-width helper.
package ntt_pkg;

    localparam int N_DEF       = 17;
    localparam int D_DEF       = 32;
    localparam int Q_DEF       = 65537;
    localparam int ENG_LAT_DEF = 1;

    // idx must reach 2D-1 while loading both operands.
    function automatic int idx_w(input int d);
        return $clog2(d) + 1;
    endfunction

    localparam int IDX_W = idx_w(D_DEF);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        NTT_A,
        NTT_B,
        PMUL,
        INTT,
        DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiply: p_o = (a_i * b_i) mod Q.
// Ports: a_i, b_i operands (N bits), p_o fully reduced product (N bits).
module mod_mul #(
    parameter int N = 17,
    parameter int Q = 65537
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] p_o
);

    logic [2*N-1:0] prod;
    logic [2*N-1:0] rem;

    assign prod = a_i * b_i;
    assign rem  = prod % (2*N)'(Q);
    assign p_o  = rem[N-1:0];

endmodule

// File: rtl/ntt_poly_mult_ctrl.sv
// Controller computing c = INTT(NTT(a) o NTT(b)) mod Q on one shared engine.
// Ports: in_* stream a then b, out_* stream c, eng_* drive external NTT/INTT engine.
module ntt_poly_mult_ctrl
    import ntt_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int D       = D_DEF,
    parameter int Q       = Q_DEF,
    parameter int ENG_LAT = ENG_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         eng_inv,
    output logic [N*D-1:0] eng_in,
    input  logic [N*D-1:0] eng_out
);

    localparam int IW = idx_w(D);
    localparam int LW = IW - 1;
    localparam int WW = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

    ctrl_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [N-1:0]  buf_a_q [D];
    logic [N-1:0]  buf_a_d [D];
    logic [N-1:0]  buf_b_q [D];
    logic [N-1:0]  buf_b_d [D];

    logic [LW-1:0] lo;
    logic [N-1:0]  prod;
    logic          acc;
    logic          wdone;

    assign lo    = idx_q[LW-1:0];
    assign acc   = in_valid & in_ready;
    assign wdone = (wcnt_q == WW'(ENG_LAT - 1));

    mod_mul #(
        .N(N),
        .Q(Q)
    ) u_mul (
        .a_i(buf_a_q[lo]),
        .b_i(buf_b_q[lo]),
        .p_o(prod)
    );

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && (idx_q == IW'(D - 1));
    assign out_data  = (state_q == DRAIN) ? buf_a_q[lo] : '0;
    assign busy      = (state_q != IDLE);
    assign eng_inv   = (state_q == INTT);

    // Only NTT_B needs BUF_B; every other state presents BUF_A.
    always_comb begin
        eng_in = '0;
        for (int i = 0; i < D; i++) begin
            eng_in[N*i +: N] = (state_q == NTT_B) ? buf_b_q[i] : buf_a_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    buf_a_d[0] = in_data;
                    idx_d      = IW'(1);
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (acc) begin
                    // Top idx bit separates the a half from the b half.
                    if (!idx_q[IW-1]) buf_a_d[lo] = in_data;
                    else              buf_b_d[lo] = in_data;
                    if (idx_q == IW'(2*D - 1)) begin
                        idx_d   = '0;
                        state_d = NTT_A;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            NTT_A, NTT_B, INTT: begin
                if (wdone) begin
                    wcnt_d = '0;
                    for (int i = 0; i < D; i++) begin
                        if (state_q == NTT_B) buf_b_d[i] = eng_out[N*i +: N];
                        else                  buf_a_d[i] = eng_out[N*i +: N];
                    end
                    unique case (state_q)
                        NTT_A:   state_d = NTT_B;
                        NTT_B:   state_d = PMUL;
                        default: state_d = DRAIN;
                    endcase
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            PMUL: begin
                buf_a_d[lo] = prod;
                if (idx_q == IW'(D - 1)) begin
                    idx_d   = '0;
                    state_d = INTT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_q == IW'(D - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            for (int i = 0; i < D; i++) begin
                buf_a_q[i] <= '0;
                buf_b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
        end
    end

endmodule

// File: tb/tb_ntt_poly_mult_ctrl.sv
// Bench for ntt_poly_mult_ctrl with behavioural ntt/intt engines.
// Scoreboard of golden cyclic convolutions checked beat by beat on the output.
module tb_ntt_poly_mult_ctrl;

    localparam int N   = 17;
    localparam int D   = 32;
    localparam int Q   = 65537;
    localparam int LAT = 1;
    localparam longint QL = 65537;

    typedef int vec_t [D];
    typedef struct {
        int data;
        bit last;
    } exp_t;

    function automatic longint modpow(input longint b, input longint e);
        longint r, bb, ee;
        r  = 1;
        bb = b % QL;
        ee = e;
        while (ee > 0) begin
            if ((ee & 1) != 0) r = (r * bb) % QL;
            bb = (bb * bb) % QL;
            ee = ee >> 1;
        end
        return r;
    endfunction

    localparam longint W    = modpow(3, (QL - 1) / D);
    localparam longint WI   = modpow(W, D - 1);
    localparam longint DINV = modpow(D, QL - 2);

    function automatic logic [N*D-1:0] eng_fn(input logic [N*D-1:0] x,
                                              input bit inv);
        longint wp [D];
        longint a;
        logic [N*D-1:0] r;
        r = '0;
        wp[0] = 1;
        for (int k = 1; k < D; k++) wp[k] = (wp[k-1] * (inv ? WI : W)) % QL;
        for (int k = 0; k < D; k++) begin
            a = 0;
            for (int j = 0; j < D; j++) begin
                a = (a + longint'(x[N*j +: N]) * wp[(j*k) % D]) % QL;
            end
            if (inv) a = (a * DINV) % QL;
            r[N*k +: N] = a[N-1:0];
        end
        return r;
    endfunction

    logic clk, rst_n;
    logic in_valid, in_ready;
    logic [N-1:0] in_data;
    logic out_valid, out_ready, out_last;
    logic [N-1:0] out_data;
    logic busy, eng_inv;
    logic [N*D-1:0] eng_in, eng_out, ntt_out, intt_out;

    assign ntt_out  = eng_fn(eng_in, 1'b0);
    assign intt_out = eng_fn(eng_in, 1'b1);
    assign eng_out  = eng_inv ? intt_out : ntt_out;

    ntt_poly_mult_ctrl #(
        .N(N), .D(D), .Q(Q), .ENG_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .eng_inv(eng_inv),
        .eng_in(eng_in), .eng_out(eng_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    exp_t sb [$];
    bit rnd_rdy = 0;
    int lat_e0 = 0;
    int rise_cyc = -1;
    bit pv = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("in_ready_drain", {31'd0, in_ready}, 0);
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    chk("out_data", {15'd0, out_data}, sb[0].data);
                    chk("out_last", {31'd0, out_last}, {31'd0, sb[0].last});
                    if (out_ready) void'(sb.pop_front());
                end
                if (!pv) rise_cyc = cyc;
            end
            pv = out_valid;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic sb_push(input vec_t a, input vec_t b);
        exp_t e;
        longint s;
        for (int k = 0; k < D; k++) begin
            s = 0;
            for (int j = 0; j < D; j++) begin
                s = (s + longint'(a[j]) * longint'(b[(k - j + D) % D])) % QL;
            end
            e.data = int'(s);
            e.last = (k == D - 1);
            sb.push_back(e);
        end
    endtask

    task automatic put(input int d, input bit last, input int gmax,
                       input bit hold, output bit ok);
        int g, t;
        g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = N'(d);
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 4000) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            t++;
        end
        #1;
        if (!ok) chk("in_accept_timeout", {31'd0, ok}, 1);
        if (last) lat_e0 = cyc;
        if (!(last && hold)) in_valid = 1'b0;
    endtask

    task automatic run_job(input vec_t a, input vec_t b, input int gmax,
                           input bit hold, input bit first_chk);
        bit ok;
        sb_push(a, b);
        for (int i = 0; i < 2*D; i++) begin
            put((i < D) ? a[i] : b[i - D], (i == 2*D - 1), gmax, hold, ok);
            if (i == 0 && first_chk) chk("b2b_first_accept_sb", sb.size(), D);
        end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (t < 3000 && !(sb.size() == 0 && !busy)) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({tag, "_sb_left"}, sb.size(), 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        chk({tag, "_out_last"}, {31'd0, out_last}, 0);
        chk({tag, "_out_data"}, {15'd0, out_data}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_eng_inv"}, {31'd0, eng_inv}, 0);
    endtask

    vec_t a1, a2, a3, b1, b3;

    initial begin
        for (int i = 0; i < D; i++) begin
            a1[i] = (i == 0) ? 1 : 0;
            a2[i] = (i == 1) ? 1 : 0;
            b1[i] = i + 1;
            a3[i] = i + 1;
            b3[i] = D - i;
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_job(a1, b1, 0, 0, 0);
        wait_done("t1");
        chk("t1_latency", rise_cyc - lat_e0, 3*LAT + D);

        run_job(a2, b1, 0, 0, 0);
        wait_done("t2");
        chk("t2_latency", rise_cyc - lat_e0, 3*LAT + D);

        run_job(a3, b3, 0, 0, 0);
        wait_done("t3");

        rnd_rdy = 1;
        run_job(a3, b3, 3, 0, 0);
        wait_done("t4");
        chk("t4_latency", rise_cyc - lat_e0, 3*LAT + D);
        rnd_rdy = 0;

        run_job(a1, b1, 0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(a1, b1, 0, 0, 0);
        wait_done("t5");
        chk("t5_latency", rise_cyc - lat_e0, 3*LAT + D);

        run_job(a3, b3, 0, 1, 0);
        in_data = N'(a1[0]);
        run_job(a1, b1, 0, 0, 1);
        wait_done("t6");
        chk("t6_latency", rise_cyc - lat_e0, 3*LAT + D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_poly_mult_ctrl.md
# ntt_poly_mult_ctrl

Sequential controller that time-shares one NTT/INTT engine for a complete polynomial product c = INTT(NTT(a) ∘ NTT(b)) mod Q. It accepts both operand polynomials as a coefficient stream, drives the engine three times (NTT a, NTT b, INTT), performs the pointwise product itself, and streams c out. It sits between the coefficient-stream front end and the shared wide `ntt`/`intt` engine; that engine is combinational or has a fixed latency.

## Interface
- `N`, 17: coefficient width in bits.
- `D`, 32: polynomial length, a power of two.
- `Q`, 65537: prime modulus, Q < 2^N.
- `ENG_LAT`, 1: cycles from a stable engine input to a valid engine output, ≥1.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: input coefficient valid.
- `in_ready` out 1: controller accepts a coefficient.
- `in_data` in N: coefficient, range 0..Q-1.
- `out_valid` out 1: result coefficient valid.
- `out_ready` in 1: sink accepts a coefficient.
- `out_data` out N: coefficient of c.
- `out_last` out 1: marks coefficient D-1.
- `busy` out 1: high in every state except IDLE.
- `eng_inv` out 1: 0 selects forward NTT, 1 selects INTT (including D⁻¹ scaling).
- `eng_in` out N·D: engine operand; coefficient i is at bits [N(i+1)-1:Ni].
- `eng_out` in N·D: engine result, same packing.

## Operation
- Storage: two buffers, BUF_A and BUF_B, each D×N. There is one index counter `idx` of log2(D)+1 bits and one wait counter `wcnt`.
- States are IDLE, LOAD, NTT_A, NTT_B, PMUL, INTT and DRAIN.
- IDLE: `in_ready`=1. The first accepted beat writes BUF_A[0] and moves to LOAD with idx=1.
- LOAD: `in_ready`=1.
  - Beats 0..D-1 fill BUF_A[0..D-1].
  - Beats D..2D-1 fill BUF_B[0..D-1].
  - After the beat with idx=2D-1 is accepted, go to NTT_A.
- NTT_A: `eng_inv`=0 and `eng_in`=BUF_A. After ENG_LAT cycles, BUF_A ← `eng_out` and go to NTT_B.
- NTT_B: same as NTT_A, using BUF_B. Then go to PMUL.
- PMUL: one coefficient per cycle, idx 0..D-1: BUF_A[idx] ← (BUF_A[idx]·BUF_B[idx]) mod Q.
  - The product is 2N bits wide and is reduced fully into 0..Q-1.
  - After idx=D-1, go to INTT.
- INTT: `eng_inv`=1 and `eng_in`=BUF_A. After ENG_LAT cycles, BUF_A ← `eng_out` and go to DRAIN.
- DRAIN:
  - `out_valid`=1 and `out_data`=BUF_A[idx].
  - idx advances only when `out_valid`&`out_ready`.
  - `out_last`=1 when idx=D-1.
  - The handshake on the last beat returns the block to IDLE.
- `in_ready`=0 in every state except IDLE and LOAD.
- `out_valid`=0 in every state except DRAIN.
- `in_valid` with `in_ready`=0 is ignored; that data is not lost from the source's point of view.
- `eng_in` is stable for the whole engine-wait window. Outside NTT_A, NTT_B and INTT its value is don't-care, but it is driven from BUF_A with no X.
- Input values ≥ Q are not checked; the result is then undefined, but no lockup may occur.

## Timing
- Reset values:
  - state=IDLE, idx=0, wcnt=0.
  - `in_ready`=1.
  - `out_valid`=0, `out_last`=0, `out_data`=0.
  - `busy`=0, `eng_inv`=0.
  - Buffers are cleared to 0.
- Reset asserted mid-operation aborts immediately. A partially streamed result is discarded and no `out_last` is emitted.
- Load takes ≥2D cycles; each cycle with `in_valid` low stalls by one cycle.
- The first `out_valid` rises exactly 3·ENG_LAT + D clock edges after the edge that accepts the last input beat. For the defaults that is 35.
- With `out_ready` held high, drain takes D cycles and IDLE is re-entered on the edge of the last handshake.
- `out_ready` low holds `out_data` and `out_last` stable.
- The block accepts a new polynomial pair only after returning to IDLE; there is no overlap between jobs.

## Structure
- The shared package `ntt_pkg` holds:
  - the defaults for N, D, Q and ENG_LAT;
  - the state enum `ctrl_state_t`;
  - the index-width constant, log2(D)+1.
- Sub-module `mod_mul`: combinational N×N → N multiply with reduction mod Q, instantiated once and used in PMUL.
- The engine itself is instantiated outside this block. The bench wires `ntt` for `eng_inv`=0 and `intt` for `eng_inv`=1 through a mux.

## Test plan
- a=[1,0,…,0], b_i=i+1, `out_ready`=1 → c_i=i+1 for all i; `out_last` only on i=31; first `out_valid` 35 edges after the last input edge.
- a=[0,1,0,…,0], b_i=i+1 → c_0=32 and c_i=i for i=1..31, a cyclic rotation.
- a_i=i+1, b_i=32-i → c equals a golden cyclic convolution mod 65537, compared per coefficient.
- Random `in_valid` gaps and random `out_ready` stalls on the test 3 vectors → identical c; `out_data` stable on every stalled cycle.
- `rst_n` pulsed during PMUL, then the test 1 vectors loaded → outputs at reset values immediately, then a correct full result.
- Two back-to-back jobs, with the second job's `in_valid` held high during the first job → no beat accepted while `busy`; the second job starts in IDLE and both results are correct.
